inst_encoder: RTL and testbench

Instruction encoder: the inverse of the control-unit decoder. It accepts decoded instruction fields (kind, fn3, alt bit, registers, immediate) over a valid/ready handshake, packs them into legal RV32I/Zicsr instruction words, and buffers them in a small FIFO for the debug program buffer and self-test injection path ahead of fetch. Illegal field combinations are consumed, dropped, and flagged.

---
 rtl/inst_pkg.sv | 41 ++++
 rtl/inst_fifo.sv | 59 +++++
 rtl/inst_encoder.sv | 139 +++++++++++++
 tb/tb_inst_encoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_pkg.sv
// Shared instruction-set constants: field-bundle kind codes, RV32I/Zicsr major
// opcodes (same table the control-unit decoder uses) and SYSTEM fn12 values.
package inst_pkg;

   typedef enum logic [3:0] {
      K_LUI     = 4'd0,
      K_AUIPC   = 4'd1,
      K_OPIMM   = 4'd2,
      K_OP      = 4'd3,
      K_JAL     = 4'd4,
      K_JALR    = 4'd5,
      K_BRANCH  = 4'd6,
      K_LOAD    = 4'd7,
      K_STORE   = 4'd8,
      K_MISCMEM = 4'd9,
      K_PRIV    = 4'd10,
      K_CSR     = 4'd11
   } kind_e;

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

   localparam logic [11:0] FN12_ECALL  = 12'h000;
   localparam logic [11:0] FN12_EBREAK = 12'h001;
   localparam logic [11:0] FN12_MRET   = 12'h302;

   // funct7 for OP and the upper immediate of OPIMM shifts: only bit 30 varies.
   function automatic logic [6:0] fn7_alt(input logic alt);
      return {1'b0, alt, 5'b00000};
   endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous word FIFO with occupancy count; a push into a full FIFO is taken
// when a pop happens in the same cycle. Power-of-two DEPTH, pointers wrap.
module inst_fifo #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [XLEN-1:0]        wdata,
   output logic [XLEN-1:0]        rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q, count_d;
   logic            do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // NOTE: storage is deliberately left unreset; only the pointers and count
   // define validity, and rdata is forced to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = empty ? '0 : mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/inst_encoder.sv
// Packs decoded field bundles into RV32I/Zicsr words: encode stage S1, then a
// FIFO. Illegal bundles are dropped at the S1 drain and raise the sticky err.
module inst_encoder
   import inst_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             in_kind,
   input  logic [2:0]             in_fn3,
   input  logic                   in_alt,
   input  logic [4:0]             in_rd,
   input  logic [4:0]             in_rs1,
   input  logic [4:0]             in_rs2,
   input  logic [XLEN-1:0]        in_imm,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [XLEN-1:0]        out_inst,
   output logic [$clog2(DEPTH):0] count,
   output logic                   err,
   input  logic                   err_clr
);
   logic [XLEN-1:0] enc_word;
   logic            enc_legal;
   logic            s1_valid_q, s1_valid_d, s1_legal_q, s1_legal_d;
   logic [XLEN-1:0] s1_inst_q, s1_inst_d;
   logic            err_q, err_d;
   logic            fifo_full, fifo_empty, fifo_push, fifo_pop, accept, s1_drop;

   // NOTE: every output of this block gets a default first so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      enc_word  = '0;
      enc_legal = 1'b1;
      case (in_kind)
         K_LUI:   enc_word = {in_imm[31:12], in_rd, OPC_LUI};
         K_AUIPC: enc_word = {in_imm[31:12], in_rd, OPC_AUIPC};
         K_OPIMM: begin
            if (in_fn3 == 3'b001 || in_fn3 == 3'b101)
               enc_word = {fn7_alt(in_alt), in_imm[4:0], in_rs1, in_fn3, in_rd, OPC_OPIMM};
            else
               enc_word = {in_imm[11:0], in_rs1, in_fn3, in_rd, OPC_OPIMM};
            enc_legal = !in_alt || (in_fn3 == 3'b101);
         end
         K_OP: begin
            enc_word  = {fn7_alt(in_alt), in_rs2, in_rs1, in_fn3, in_rd, OPC_OP};
            enc_legal = !in_alt || (in_fn3 == 3'b000) || (in_fn3 == 3'b101);
         end
         K_JAL: begin
            enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
            enc_legal = !in_imm[0];
         end
         K_JALR: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
         K_BRANCH: begin
            enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_fn3,
                         in_imm[4:1], in_imm[11], OPC_BRANCH};
            enc_legal = !in_imm[0] && (in_fn3 != 3'b010) && (in_fn3 != 3'b011);
         end
         K_LOAD: begin
            enc_word  = {in_imm[11:0], in_rs1, in_fn3, in_rd, OPC_LOAD};
            enc_legal = (in_fn3 != 3'b011) && (in_fn3 != 3'b110) && (in_fn3 != 3'b111);
         end
         K_STORE: begin
            enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_fn3, in_imm[4:0], OPC_STORE};
            enc_legal = (in_fn3 < 3'b011);
         end
         K_MISCMEM: begin
            enc_word  = {12'h000, in_rs1, in_fn3, in_rd, OPC_MISCMEM};
            enc_legal = (in_fn3 <= 3'b001);
         end
         K_PRIV: begin
            enc_word  = {in_imm[11:0], 13'h0000, OPC_SYSTEM};
            enc_legal = (in_imm[11:0] == FN12_ECALL) || (in_imm[11:0] == FN12_EBREAK) ||
                        (in_imm[11:0] == FN12_MRET);
         end
         K_CSR: begin
            enc_word  = {in_imm[11:0], in_rs1, in_fn3, in_rd, OPC_SYSTEM};
            enc_legal = (in_fn3 != 3'b000) && (in_fn3 != 3'b100);
         end
         default: enc_legal = 1'b0;
      endcase
   end

   // S1 always empties in one cycle unless it holds a legal word facing a full,
   // non-popping FIFO; that is the only back-pressure seen upstream.
   assign in_ready  = !s1_valid_q || !s1_legal_q || !fifo_full || out_ready;
   assign accept    = in_valid && in_ready;
   assign fifo_pop  = out_ready && !fifo_empty;
   assign fifo_push = s1_valid_q && s1_legal_q && (!fifo_full || fifo_pop);
   assign s1_drop   = s1_valid_q && !s1_legal_q;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_legal_d = s1_legal_q;
      s1_inst_d  = s1_inst_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_legal_d = enc_legal;
         s1_inst_d  = enc_word;
      end else if (fifo_push || s1_drop) begin
         s1_valid_d = 1'b0;
      end
      err_d = s1_drop ? 1'b1 : (err_clr ? 1'b0 : err_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_legal_q <= 1'b0;
         s1_inst_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_legal_q <= s1_legal_d;
         s1_inst_q  <= s1_inst_d;
         err_q      <= err_d;
      end
   end

   inst_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (s1_inst_q),
      .rdata (out_inst),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   assign out_valid = !fifo_empty;
   assign err       = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: the driver queues hand-computed words for
// legal bundles, a monitor compares every FIFO pop against that queue.
module tb_inst_encoder;
   import inst_pkg::*;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid, in_ready, in_alt, out_valid, out_ready, err, err_clr;
   logic [3:0]        in_kind;
   logic [2:0]        in_fn3;
   logic [4:0]        in_rd, in_rs1, in_rs2;
   logic [XLEN-1:0]   in_imm, out_inst;
   logic [$clog2(DEPTH):0] count;

   logic [31:0] sb [$];
   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0]  k;
      logic [2:0]  f3;
      logic        a;
      logic [31:0] imm;
   } ill_t;
   ill_t ill [13];

   always #5 clk = ~clk;

   inst_encoder #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_kind   (in_kind),
      .in_fn3    (in_fn3),
      .in_alt    (in_alt),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .count     (count),
      .err       (err),
      .err_clr   (err_clr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change only 1ns after a rising edge; outputs are read on falling edges.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_in_ready"},  32'(in_ready),  32'd1);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_out_inst"},  out_inst,       32'd0);
      check({tag, "_count"},     32'(count),     32'd0);
      check({tag, "_err"},       32'(err),       32'd0);
   endtask

   task automatic send(input logic [3:0] k, input logic [2:0] f3, input logic a,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic legal, input logic [31:0] exp);
      bit acc = 1'b0;
      in_kind = k; in_fn3 = f3; in_alt = a;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      in_valid = 1'b1;
      for (int w = 0; w < 20 && !acc; w++) begin
         @(negedge clk);
         acc = in_ready;
         tick();
      end
      in_valid = 1'b0;
      check("send_accept", 32'(acc), 32'd1);
      if (acc && legal) sb.push_back(exp);
   endtask

   task automatic drain(input string name);
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !out_valid) break;
      end
      check(name, 32'(count), 32'd0);
      tick();
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid && out_ready) begin
         if (sb.size() == 0) check("pop_unexpected", 32'(out_valid), 32'd0);
         else check("pop_word", out_inst, sb.pop_front());
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ill[0]  = '{4'd12,      3'd0, 1'b0, 32'd0};
      ill[1]  = '{4'd15,      3'd0, 1'b0, 32'd0};
      ill[2]  = '{K_BRANCH,   3'd0, 1'b0, 32'd3};
      ill[3]  = '{K_BRANCH,   3'd2, 1'b0, 32'd4};
      ill[4]  = '{K_JAL,      3'd0, 1'b0, 32'd1};
      ill[5]  = '{K_LOAD,     3'd3, 1'b0, 32'd0};
      ill[6]  = '{K_STORE,    3'd3, 1'b0, 32'd0};
      ill[7]  = '{K_OP,       3'd1, 1'b1, 32'd0};
      ill[8]  = '{K_OPIMM,    3'd0, 1'b1, 32'd0};
      ill[9]  = '{K_MISCMEM,  3'd2, 1'b0, 32'd0};
      ill[10] = '{K_CSR,      3'd0, 1'b0, 32'd0};
      ill[11] = '{K_CSR,      3'd4, 1'b0, 32'd0};
      ill[12] = '{K_PRIV,     3'd0, 1'b0, 32'h105};

      rst_n = 1'b0; in_valid = 1'b0; in_kind = '0; in_fn3 = '0; in_alt = 1'b0;
      in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; out_ready = 1'b0; err_clr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset("rst");
      tick();
      rst_n = 1'b1;

      // Directed encodings at full rate.
      out_ready = 1'b1;
      send(K_LUI,     3'd0, 1'b0, 5'd5,  5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123452B7);
      send(K_OPIMM,   3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'd1,        1'b1, 32'h00100093);
      send(K_OP,      3'd0, 1'b1, 5'd3,  5'd1, 5'd2, 32'd0,        1'b1, 32'h402081B3);
      send(K_BRANCH,  3'd0, 1'b0, 5'd0,  5'd1, 5'd2, 32'hFFFFFFFC, 1'b1, 32'hFE208EE3);
      send(K_JAL,     3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'd8,        1'b1, 32'h008000EF);
      send(K_PRIV,    3'd5, 1'b0, 5'd7,  5'd3, 5'd0, 32'h302,      1'b1, 32'h30200073);
      send(K_CSR,     3'd2, 1'b0, 5'd5,  5'd0, 5'd0, 32'h300,      1'b1, 32'h300022F3);
      send(K_OPIMM,   3'd5, 1'b1, 5'd2,  5'd4, 5'd0, 32'd3,        1'b1, 32'h40325113);
      send(K_STORE,   3'd2, 1'b0, 5'd0,  5'd1, 5'd2, 32'd8,        1'b1, 32'h0020A423);
      send(K_JALR,    3'd7, 1'b0, 5'd1,  5'd5, 5'd0, 32'd4,        1'b1, 32'h004280E7);
      send(K_PRIV,    3'd5, 1'b0, 5'd7,  5'd3, 5'd0, 32'h000,      1'b1, 32'h00000073);
      send(K_MISCMEM, 3'd0, 1'b0, 5'd0,  5'd0, 5'd0, 32'hFFF,      1'b1, 32'h0000000F);
      send(K_AUIPC,   3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'hABCDE123, 1'b1, 32'hABCDE517);
      drain("drain_directed");
      repeat (3) @(negedge clk);
      check("no_underflow_count", 32'(count), 32'd0);
      tick();

      // Fill: four words in the FIFO, fifth held in S1.
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++)
         send(K_OPIMM, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'(i), 1'b1, 32'h00000093 | (32'(i) << 20));
      @(negedge clk);
      check("full_count",     32'(count),     32'd4);
      check("full_in_ready",  32'(in_ready),  32'd0);
      check("full_out_valid", 32'(out_valid), 32'd1);
      tick();
      @(negedge clk);
      check("held_count",    32'(count),    32'd4);
      check("held_in_ready", 32'(in_ready), 32'd0);
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      check("pulse_in_ready", 32'(in_ready), 32'd1);
      tick();
      out_ready = 1'b0;
      @(negedge clk);
      check("pushpop_count",    32'(count),    32'd4);
      check("pushpop_in_ready", 32'(in_ready), 32'd1);
      tick();
      drain("drain_full");

      // Illegal bundles: dropped, err set, FIFO untouched, no stall.
      for (int i = 0; i < 13; i++) begin
         err_clr = 1'b1;
         tick();
         err_clr = 1'b0;
         @(negedge clk);
         check($sformatf("ill%0d_clr", i), 32'(err), 32'd0);
         tick();
         send(ill[i].k, ill[i].f3, ill[i].a, 5'd0, 5'd0, 5'd0, ill[i].imm, 1'b0, 32'd0);
         @(negedge clk);
         check($sformatf("ill%0d_in_ready", i), 32'(in_ready), 32'd1);
         tick();
         @(negedge clk);
         check($sformatf("ill%0d_err", i),   32'(err),   32'd1);
         check($sformatf("ill%0d_count", i), 32'(count), 32'd0);
         tick();
      end

      // Set and clear in the same cycle: set wins.
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      @(negedge clk);
      check("clr_before_set", 32'(err), 32'd0);
      tick();
      send(K_BRANCH, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'd0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      @(negedge clk);
      check("set_wins", 32'(err), 32'd1);
      tick();

      // Mid-stream reset with three queued words and S1 full.
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++)
         send(K_LUI, 3'd0, 1'b0, 5'(i), 5'd0, 5'd0, 32'(i) << 12, 1'b1,
              (32'(i) << 12) | (32'(i) << 7) | 32'h37);
      @(negedge clk);
      check("pre_rst_count",     32'(count),     32'd3);
      check("pre_rst_out_valid", 32'(out_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1 check_reset("midrst");
      sb.delete();
      tick();
      tick();
      rst_n = 1'b1;

      // Post-reset latency: invisible after the accept edge, visible after the next.
      send(K_LUI, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123452B7);
      @(negedge clk);
      check("lat_accept_out_valid", 32'(out_valid), 32'd0);
      tick();
      @(negedge clk);
      check("lat_push_out_valid", 32'(out_valid), 32'd1);
      check("lat_push_count",     32'(count),     32'd1);
      check("lat_push_out_inst",  out_inst,       32'h123452B7);
      tick();
      drain("drain_end");
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
